// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with bursts capped at BURST_LEN beats.
// Optional macro FIFO_WR_ARB_ALM_THROTTLE_EN: almost-full blocks new grants and ends a burst early.
module fifo_wr_arb #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 128,
   parameter int BURST_LEN = 8,
   localparam int OWN_W    = $clog2(NUM_REQ),
   localparam int BW       = $clog2(BURST_LEN + 1)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*DATA_W-1:0] i_data,
   input  logic                      i_fifo_full,
   input  logic                      i_fifo_alm_full,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic                      o_wren,
   output logic [DATA_W-1:0]         o_wrdata,
   output logic                      o_busy,
   output logic [OWN_W-1:0]          o_owner
);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_STALL} state_t;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

`ifdef FIFO_WR_ARB_ALM_THROTTLE_EN
   localparam logic THROTTLE = 1'b1;
`else
   localparam logic THROTTLE = 1'b0;
`endif

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [OWN_W-1:0]   r_owner;
   logic [OWN_W-1:0]   r_ptr;
   logic [BW-1:0]      r_beats;

   logic               w_throttle;
   logic               w_own_req;
   logic               w_found;
   logic [OWN_W-1:0]   w_next;
   logic [OWN_W-1:0]   w_cand;
   int                 w_idx;
   logic               w_end;

   assign w_throttle = THROTTLE & i_fifo_alm_full;
   assign w_own_req  = i_req[r_owner];

   // Search upward from the slot after the last owner so every waiting requester gets its turn.
   always_comb begin
      w_found = 1'b0;
      w_next  = '0;
      w_idx   = 0;
      w_cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = int'(r_ptr) + i;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         w_cand = OWN_W'(w_idx);
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_next  = w_cand;
         end
      end
   end

   always_comb begin
      w_end = 1'b0;
      if (r_state == S_BURST)
         w_end = !w_own_req || (!i_fifo_full && ((r_beats == LAST_BEAT) || w_throttle));
      else if (r_state == S_STALL)
         w_end = !w_own_req;
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= OWN_W'(NUM_REQ - 1);
         r_beats <= '0;
      end else if (w_end) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= r_owner;
         if (r_state == S_BURST && w_own_req) r_beats <= r_beats + BW'(1);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found && !i_fifo_full && !w_throttle) begin
                  r_state <= S_BURST;
                  r_gnt   <= NUM_REQ'(1) << w_next;
                  r_owner <= w_next;
                  r_beats <= '0;
               end
            end
            S_BURST: begin
               if (i_fifo_full) r_state <= S_STALL;
               else             r_beats <= r_beats + BW'(1);
            end
            S_STALL: begin
               if (!i_fifo_full) r_state <= S_BURST;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Reset is qualified in so nothing is written during the cycle that aborts a burst.
   assign o_wren   = !rstn && (r_state == S_BURST) && w_own_req && !i_fifo_full;
   assign o_wrdata = i_data[int'(r_owner)*DATA_W +: DATA_W];
   assign o_gnt    = r_gnt;
   assign o_owner  = r_owner;
   assign o_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: vector table for basic arbitration plus hand sequences for
// round-robin order, stall, early drop and mid-burst reset.
module tb_fifo_wr_arb;

   localparam int NR = 4;
   localparam int DW = 128;

   logic            clk = 1'b0;
   logic            rstn;
   logic [NR-1:0]   i_req;
   logic [NR*DW-1:0] i_data;
   logic            i_fifo_full;
   logic            i_fifo_alm_full;
   logic [NR-1:0]   o_gnt;
   logic            o_wren;
   logic [DW-1:0]   o_wrdata;
   logic            o_busy;
   logic [1:0]      o_owner;

   int checks = 0;
   int errors = 0;
   int seq[NR];

   typedef struct {
      logic [3:0] req;
      logic       full;
      logic       alm;
      logic [3:0] gnt;
      logic       wren;
      logic       busy;
      logic [1:0] own;
   } vec_t;

   vec_t tbl[$];

   fifo_wr_arb #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(8)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .i_req          (i_req),
      .i_data         (i_data),
      .i_fifo_full    (i_fifo_full),
      .i_fifo_alm_full(i_fifo_alm_full),
      .o_gnt          (o_gnt),
      .o_wren         (o_wren),
      .o_wrdata       (o_wrdata),
      .o_busy         (o_busy),
      .o_owner        (o_owner)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int k, input int s);
      return DW'({8'hA5, 8'(k), 16'(s)});
   endfunction

   function automatic void add(input logic [3:0] req, input logic full, input logic alm,
                               input logic [3:0] gnt, input logic wren, input logic busy,
                               input logic [1:0] own);
      vec_t v;
      v.req = req; v.full = full; v.alm = alm;
      v.gnt = gnt; v.wren = wren; v.busy = busy; v.own = own;
      tbl.push_back(v);
   endfunction

   task automatic drive_data();
      for (int k = 0; k < NR; k++) i_data[k*DW +: DW] = mk(k, seq[k]);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   // Check one cycle's outputs, advance the requester model on an expected beat, then clock.
   task automatic cyc(input string tag, input logic [3:0] eg, input logic ew,
                      input logic eb, input logic [1:0] eo);
      #1;
      chk({tag, ".gnt"},   128'(o_gnt),   128'(eg));
      chk({tag, ".wren"},  128'(o_wren),  128'(ew));
      chk({tag, ".busy"},  128'(o_busy),  128'(eb));
      chk({tag, ".owner"}, 128'(o_owner), 128'(eo));
      if (ew) begin
         chk({tag, ".wrdata"}, 128'(o_wrdata), 128'(mk(int'(eo), seq[eo])));
         seq[eo]++;
      end
      @(posedge clk);
      #1;
      drive_data();
   endtask

   task automatic do_reset();
      rstn = 1'b1;
      i_req = '0;
      i_fifo_full = 1'b0;
      i_fifo_alm_full = 1'b0;
      for (int k = 0; k < NR; k++) seq[k] = 0;
      drive_data();
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b0;
   endtask

   initial begin
      int ord[5];
      ord = '{0, 1, 2, 3, 0};

      // Table: single requester full burst, bubble, re-grant, early drop, full and almost-full in IDLE.
      add(4'b0001, 0, 0, 4'b0000, 0, 0, 2'd0);
      for (int b = 0; b < 8; b++) add(4'b0001, 0, 0, 4'b0001, 1, 1, 2'd0);
      add(4'b0001, 0, 0, 4'b0000, 0, 0, 2'd0);
      add(4'b0001, 0, 0, 4'b0001, 1, 1, 2'd0);
      add(4'b0000, 0, 0, 4'b0001, 0, 1, 2'd0);
      add(4'b0110, 1, 0, 4'b0000, 0, 0, 2'd0);
      add(4'b0110, 0, 1, 4'b0000, 0, 0, 2'd0);
`ifdef FIFO_WR_ARB_ALM_THROTTLE_EN
      add(4'b0000, 0, 1, 4'b0000, 0, 0, 2'd0);
`else
      add(4'b0000, 0, 1, 4'b0010, 0, 1, 2'd1);
`endif
      add(4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0);

      do_reset();
      foreach (tbl[i]) begin
         i_req = tbl[i].req;
         i_fifo_full = tbl[i].full;
         i_fifo_alm_full = tbl[i].alm;
         cyc($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].wren, tbl[i].busy, tbl[i].own);
      end

      // All four requesting: order 0,1,2,3,0 with one bubble between grants.
      do_reset();
      i_req = 4'b1111;
      cyc("rr.idle", 4'b0000, 0, 0, 2'd0);
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < 8; b++)
            cyc($sformatf("rr.g%0d.b%0d", g, b), 4'(1 << ord[g]), 1, 1, 2'(ord[g]));
         cyc($sformatf("rr.bub%0d", g), 4'b0000, 0, 0, 2'd0);
      end

      // Owner 2 stalls for 5 full cycles after 3 beats, then finishes its 8 beats.
      do_reset();
      i_req = 4'b0100;
      cyc("st.idle", 4'b0000, 0, 0, 2'd0);
      for (int b = 0; b < 3; b++) cyc($sformatf("st.pre%0d", b), 4'b0100, 1, 1, 2'd2);
      i_fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) cyc($sformatf("st.full%0d", c), 4'b0100, 0, 1, 2'd2);
      i_fifo_full = 1'b0;
      cyc("st.exit", 4'b0100, 0, 1, 2'd2);
      for (int b = 0; b < 5; b++) cyc($sformatf("st.post%0d", b), 4'b0100, 1, 1, 2'd2);
      cyc("st.bub", 4'b0000, 0, 0, 2'd0);
      cyc("st.rg", 4'b0100, 1, 1, 2'd2);
      i_fifo_full = 1'b1;
      cyc("st.full2", 4'b0100, 0, 1, 2'd2);
      i_req = 4'b0000;
      cyc("st.drop", 4'b0100, 0, 1, 2'd2);
      i_fifo_full = 1'b0;
      cyc("st.end", 4'b0000, 0, 0, 2'd0);

      // Owner 1 drops after 3 beats; grant passes to requester 2.
      do_reset();
      i_req = 4'b0110;
      cyc("dr.idle", 4'b0000, 0, 0, 2'd0);
      for (int b = 0; b < 3; b++) cyc($sformatf("dr.b%0d", b), 4'b0010, 1, 1, 2'd1);
      i_req = 4'b0100;
      cyc("dr.drop", 4'b0010, 0, 1, 2'd1);
      cyc("dr.bub", 4'b0000, 0, 0, 2'd0);
      cyc("dr.next", 4'b0100, 1, 1, 2'd2);

      // Reset during beat 4 of owner 3 aborts without writing; requester 0 wins afterwards.
      do_reset();
      i_req = 4'b1000;
      cyc("rs.idle", 4'b0000, 0, 0, 2'd0);
      for (int b = 0; b < 3; b++) cyc($sformatf("rs.b%0d", b), 4'b1000, 1, 1, 2'd3);
      rstn = 1'b1;
      cyc("rs.rstcyc", 4'b1000, 0, 1, 2'd3);
      rstn = 1'b0;
      i_req = 4'b1001;
      cyc("rs.after", 4'b0000, 0, 0, 2'd0);
      cyc("rs.gnt0", 4'b0001, 1, 1, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4; number of write requesters sharing one FIFO write port (2..8).
REQ-002 Parameter DATA_W, default 128; write data width.
REQ-003 Parameter BURST_LEN, default 8; maximum beats per grant before forced re-arbitration (1..256).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rstn  input  1  reset; synchronous and active-high (asserted = 1).
REQ-006 i_req  input  NUM_REQ  per-requester write request; bit k held while requester k has data.
REQ-007 i_data  input  NUM_REQ*DATA_W  requester k data in slice [k*DATA_W +: DATA_W].
REQ-008 i_fifo_full  input  1  FIFO full flag.
REQ-009 i_fifo_alm_full  input  1  FIFO almost-full flag.
REQ-010 o_gnt  output  NUM_REQ  registered one-hot grant (all-zero when none).
REQ-011 o_wren  output  1  FIFO write enable.
REQ-012 o_wrdata  output  DATA_W  FIFO write data.
REQ-013 o_busy  output  1  high when state is not IDLE.
REQ-014 o_owner  output  clog2(NUM_REQ)  index of current grant holder; 0 when idle.

Function
REQ-015 FSM states: IDLE, BURST, STALL; state, o_gnt, o_owner, round-robin pointer, beat counter are registers.
REQ-016 IDLE: if any i_req set and i_fifo_full=0 -> BURST next cycle; o_gnt = one-hot of first set request searching upward from (last owner + 1) modulo NUM_REQ; beat counter cleared.
REQ-017 o_wren = (state==BURST) & i_req[o_owner] & ~i_fifo_full, combinational; o_wrdata = i_data slice of o_owner, combinational, regardless of o_wren.
REQ-018 Beat accepted on a rising edge where o_wren=1; o_gnt[k] with o_wren is the requester's acknowledge; requester presents next word the following cycle.
REQ-019 BURST: each accepted beat increments beat counter (width clog2(BURST_LEN+1), no wrap).
REQ-020 BURST -> IDLE when owner's i_req=0, or when the accepted beat is beat number BURST_LEN; o_gnt clears and round-robin pointer records the owner in the same edge.
REQ-021 BURST -> STALL when i_fifo_full=1 and owner still requests; no beat accepted that cycle.
REQ-022 STALL: o_wren=0, grant held; -> BURST when i_fifo_full=0; -> IDLE if owner drops i_req.
REQ-023 Grant latency: request in IDLE at edge N gives o_gnt at N+1; one idle bubble cycle between consecutive grants.
REQ-024 Requests from non-owners never affect o_wren, o_wrdata or the active burst.
REQ-025 No requester is granted twice while another requester has continuously requested (starvation-free).

Reset
REQ-026 rstn=1 at a rising edge: state=IDLE, o_gnt=0, o_owner=0, o_busy=0, beat counter=0, pointer set so requester 0 has first priority; o_wren=0 while in IDLE.
REQ-027 Reset mid-burst or mid-stall aborts the grant in the same edge; no write occurs in the reset cycle.

Configuration
REQ-028 Macro FIFO_WR_ARB_ALM_THROTTLE_EN: when defined, IDLE issues no new grant while i_fifo_alm_full=1, and BURST ends (-> IDLE) after the beat accepted with i_fifo_alm_full=1; when undefined, i_fifo_alm_full is ignored.

Verification
REQ-029 Reset, then i_req=4'b0001, data 0xA5 constant, full=0 -> o_gnt=0001 one cycle later, exactly 8 writes of 0xA5, then IDLE bubble, re-grant to 0.
REQ-030 i_req=4'b1111 held, full=0 -> grant order 0,1,2,3,0, each 8 beats, one bubble between.
REQ-031 Owner 2 in BURST, i_fifo_full=1 for 5 cycles at beat 3 -> STALL, o_wren=0 for 5 cycles, resumes, total 8 beats, no data lost or duplicated.
REQ-032 Owner 1 drops i_req after 3 beats -> IDLE next edge, grant passes to next requester 2 if requesting.
REQ-033 rstn=1 during beat 4 of owner 3 -> o_gnt=0, o_busy=0 next edge; after release with i_req=4'b1000|0001 requester 0 granted first.
REQ-034 Macro defined, i_fifo_alm_full=1 in IDLE with requests -> no grant until it deasserts; undefined -> grant proceeds.
